// File: rtl/projectile_pool.sv
// projectile_pool
//   Pool of N_SLOTS independent projectiles for the arcade top level.
//   Fire requests arrive over a valid/ready handshake and are rate-limited
//   by a tick-based cooldown. On each move tick every active slot is first
//   checked against the enemy boxes, then bounds-checked, then moved.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   tick                : one-cycle move/collision enable
//   clear               : synchronous clear of slots, score and cooldown
//   fire_valid/ready    : fire request handshake
//   fire_x/y, fire_dx/dy: spawn position and signed per-tick velocity
//   tgt_x/y, tgt_active : flattened enemy top-left corners and valid bits
//   slot_active/x/y     : flattened slot state for the renderer
//   hit_valid, hit_mask : one-cycle hit pulse and the claimed targets
//   score               : saturating hit count
//   sfx_trig            : one-cycle pulse per loaded fire
//
// Handshake: a request transfers on a clock edge where fire_valid and
// fire_ready are both high. fire_ready is a function of registered state
// only and never looks at fire_valid. A transferred request with zero
// velocity is consumed and dropped.
module projectile_pool #(
  parameter int N_SLOTS   = 4,
  parameter int N_TARGETS = 10,
  parameter int COORD_W   = 10,
  parameter int VEL_W     = 6,
  parameter int SCR_W     = 640,
  parameter int SCR_H     = 480,
  parameter int MARGIN    = 5,
  parameter int BUL_W     = 5,
  parameter int BUL_H     = 10,
  parameter int TGT_SZ    = 20,
  parameter int COOLDOWN  = 3,
  parameter int SCORE_MAX = 99
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           tick,
  input  logic                           clear,
  input  logic                           fire_valid,
  output logic                           fire_ready,
  input  logic [COORD_W-1:0]             fire_x,
  input  logic [COORD_W-1:0]             fire_y,
  input  logic [VEL_W-1:0]               fire_dx,
  input  logic [VEL_W-1:0]               fire_dy,
  input  logic [N_TARGETS*COORD_W-1:0]   tgt_x,
  input  logic [N_TARGETS*COORD_W-1:0]   tgt_y,
  input  logic [N_TARGETS-1:0]           tgt_active,
  output logic [N_SLOTS-1:0]             slot_active,
  output logic [N_SLOTS*COORD_W-1:0]     slot_x,
  output logic [N_SLOTS*COORD_W-1:0]     slot_y,
  output logic                           hit_valid,
  output logic [N_TARGETS-1:0]           hit_mask,
  output logic [7:0]                     score,
  output logic                           sfx_trig
);

  localparam int CW1  = COORD_W + 1;
  localparam int CD_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

  localparam logic [COORD_W-1:0] LO_C  = COORD_W'(MARGIN);
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(SCR_W - MARGIN);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(SCR_H - MARGIN);
  localparam logic [CW1-1:0]     BW_E  = CW1'(BUL_W);
  localparam logic [CW1-1:0]     BH_E  = CW1'(BUL_H);
  localparam logic [CW1-1:0]     TS_E  = CW1'(TGT_SZ);

  logic [N_SLOTS-1:0]   active_q, active_d;
  logic [COORD_W-1:0]   x_q [N_SLOTS];
  logic [COORD_W-1:0]   x_d [N_SLOTS];
  logic [COORD_W-1:0]   y_q [N_SLOTS];
  logic [COORD_W-1:0]   y_d [N_SLOTS];
  logic [VEL_W-1:0]     dx_q [N_SLOTS];
  logic [VEL_W-1:0]     dx_d [N_SLOTS];
  logic [VEL_W-1:0]     dy_q [N_SLOTS];
  logic [VEL_W-1:0]     dy_d [N_SLOTS];
  logic [CD_W-1:0]      cd_q, cd_d;
  logic [7:0]           score_q, score_d;
  logic                 hit_valid_q, hit_valid_d;
  logic [N_TARGETS-1:0] hit_mask_q, hit_mask_d;
  logic                 sfx_q, sfx_d;

  logic [N_TARGETS-1:0] claimed;
  logic [7:0]           hit_cnt;
  logic [8:0]           score_sum;
  logic                 slot_claim;
  logic                 fire_load;
  logic                 free_found;

  // Box overlap, with sums one bit wider than the coordinates.
  function automatic logic overlaps(input logic [COORD_W-1:0] sx, input logic [COORD_W-1:0] sy,
                                    input logic [COORD_W-1:0] tx, input logic [COORD_W-1:0] ty);
    logic [CW1-1:0] sxe, sye, txe, tye;
    sxe = {1'b0, sx};
    sye = {1'b0, sy};
    txe = {1'b0, tx};
    tye = {1'b0, ty};
    return (sxe + BW_E > txe) && (sxe < txe + TS_E) &&
           (sye + BH_E > tye) && (sye < tye + TS_E);
  endfunction

  function automatic logic in_bounds(input logic [COORD_W-1:0] px, input logic [COORD_W-1:0] py);
    return (px >= LO_C) && (px <= X_MAX) && (py >= LO_C) && (py <= Y_MAX);
  endfunction

  assign fire_ready = (cd_q == '0) && !(&active_q);

  always_comb begin
    active_d    = active_q;
    x_d         = x_q;
    y_d         = y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    cd_d        = cd_q;
    claimed     = '0;
    hit_cnt     = '0;
    slot_claim  = 1'b0;
    free_found  = 1'b0;
    fire_load   = fire_valid && fire_ready && ((fire_dx != '0) || (fire_dy != '0));

    if (tick) begin
      // Slots are walked in index order so a lower slot claims a shared
      // target first; a slot whose overlaps are all taken keeps flying.
      for (int s = 0; s < N_SLOTS; s++) begin
        if (active_q[s]) begin
          slot_claim = 1'b0;
          for (int k = 0; k < N_TARGETS; k++) begin
            if (!slot_claim && tgt_active[k] && !claimed[k] &&
                overlaps(x_q[s], y_q[s], tgt_x[k*COORD_W +: COORD_W], tgt_y[k*COORD_W +: COORD_W])) begin
              claimed[k] = 1'b1;
              slot_claim = 1'b1;
            end
          end
          if (slot_claim || !in_bounds(x_q[s], y_q[s])) begin
            active_d[s] = 1'b0;
          end else begin
            x_d[s] = x_q[s] + {{(COORD_W-VEL_W){dx_q[s][VEL_W-1]}}, dx_q[s]};
            y_d[s] = y_q[s] + {{(COORD_W-VEL_W){dy_q[s][VEL_W-1]}}, dy_q[s]};
          end
        end
      end
      if (cd_q != '0) cd_d = cd_q - 1'b1;
    end

    for (int k = 0; k < N_TARGETS; k++) hit_cnt = hit_cnt + 8'(claimed[k]);
    score_sum = {1'b0, score_q} + {1'b0, hit_cnt};
    score_d   = (score_sum > 9'(SCORE_MAX)) ? 8'(SCORE_MAX) : score_sum[7:0];

    hit_valid_d = |claimed;
    hit_mask_d  = claimed;
    sfx_d       = fire_load;

    // Free slots are judged on pre-edge state, so a slot released by this
    // tick is not reused until the next cycle.
    if (fire_load) begin
      cd_d = CD_W'(COOLDOWN);
      for (int s = 0; s < N_SLOTS; s++) begin
        if (!free_found && !active_q[s]) begin
          free_found  = 1'b1;
          active_d[s] = 1'b1;
          x_d[s]      = fire_x;
          y_d[s]      = fire_y;
          dx_d[s]     = fire_dx;
          dy_d[s]     = fire_dy;
        end
      end
    end

    if (clear) begin
      active_d    = '0;
      cd_d        = '0;
      score_d     = '0;
      hit_valid_d = 1'b0;
      hit_mask_d  = '0;
      sfx_d       = 1'b0;
      for (int s = 0; s < N_SLOTS; s++) begin
        x_d[s]  = '0;
        y_d[s]  = '0;
        dx_d[s] = '0;
        dy_d[s] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q    <= '0;
      cd_q        <= '0;
      score_q     <= '0;
      hit_valid_q <= 1'b0;
      hit_mask_q  <= '0;
      sfx_q       <= 1'b0;
      for (int s = 0; s < N_SLOTS; s++) begin
        x_q[s]  <= '0;
        y_q[s]  <= '0;
        dx_q[s] <= '0;
        dy_q[s] <= '0;
      end
    end else begin
      active_q    <= active_d;
      cd_q        <= cd_d;
      score_q     <= score_d;
      hit_valid_q <= hit_valid_d;
      hit_mask_q  <= hit_mask_d;
      sfx_q       <= sfx_d;
      for (int s = 0; s < N_SLOTS; s++) begin
        x_q[s]  <= x_d[s];
        y_q[s]  <= y_d[s];
        dx_q[s] <= dx_d[s];
        dy_q[s] <= dy_d[s];
      end
    end
  end

  always_comb begin
    slot_x = '0;
    slot_y = '0;
    for (int s = 0; s < N_SLOTS; s++) begin
      slot_x[s*COORD_W +: COORD_W] = x_q[s];
      slot_y[s*COORD_W +: COORD_W] = y_q[s];
    end
  end

  assign slot_active = active_q;
  assign hit_valid   = hit_valid_q;
  assign hit_mask    = hit_mask_q;
  assign score       = score_q;
  assign sfx_trig    = sfx_q;

endmodule

// File: tb/tb_projectile_pool.sv
// Testbench for projectile_pool: directed vectors, with a scoreboard that
// checks every sfx_trig and hit_valid pulse against queued expectations.
module tb_projectile_pool;
  localparam int NS = 4;
  localparam int NT = 10;
  localparam int CW = 10;
  localparam int VW = 6;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              tick = 1'b0;
  logic              clear = 1'b0;
  logic              fire_valid = 1'b0;
  logic              fire_ready;
  logic [CW-1:0]     fire_x = '0;
  logic [CW-1:0]     fire_y = '0;
  logic [VW-1:0]     fire_dx = '0;
  logic [VW-1:0]     fire_dy = '0;
  logic [NT*CW-1:0]  tgt_x = '0;
  logic [NT*CW-1:0]  tgt_y = '0;
  logic [NT-1:0]     tgt_active = '0;
  logic [NS-1:0]     slot_active;
  logic [NS*CW-1:0]  slot_x;
  logic [NS*CW-1:0]  slot_y;
  logic              hit_valid;
  logic [NT-1:0]     hit_mask;
  logic [7:0]        score;
  logic              sfx_trig;

  always #5 clk = ~clk;

  projectile_pool dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .clear(clear),
    .fire_valid(fire_valid), .fire_ready(fire_ready),
    .fire_x(fire_x), .fire_y(fire_y), .fire_dx(fire_dx), .fire_dy(fire_dy),
    .tgt_x(tgt_x), .tgt_y(tgt_y), .tgt_active(tgt_active),
    .slot_active(slot_active), .slot_x(slot_x), .slot_y(slot_y),
    .hit_valid(hit_valid), .hit_mask(hit_mask), .score(score), .sfx_trig(sfx_trig)
  );

  // ---------------- scoreboard ----------------
  logic [NS-1:0]   exp_sfx_q[$];   // expected slot_active when sfx_trig pulses
  logic [NT+7:0]   exp_hit_q[$];   // {hit_mask, score} expected on hit_valid
  int n_cmp = 0;
  int n_err = 0;
  int exp_score = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [NS-1:0] es;
    logic [NT+7:0] eh;
    if (rst_n) begin
      if (sfx_trig) begin
        if (exp_sfx_q.size() == 0) check("sfx_unexpected", 32'(sfx_trig), 0);
        else begin
          es = exp_sfx_q.pop_front();
          check("sfx_slot_active", 32'(slot_active), 32'(es));
        end
      end
      if (hit_valid) begin
        if (exp_hit_q.size() == 0) check("hit_unexpected", 32'(hit_valid), 0);
        else begin
          eh = exp_hit_q.pop_front();
          check("hit_mask", 32'(hit_mask), 32'(eh[NT+7:8]));
          check("hit_score", 32'(score), 32'(eh[7:0]));
        end
      end else if (hit_mask != '0) begin
        check("hit_mask_idle", 32'(hit_mask), 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [CW-1:0] sx(input int s);
    return slot_x[s*CW +: CW];
  endfunction

  function automatic logic [CW-1:0] sy(input int s);
    return slot_y[s*CW +: CW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic do_fire(input int x, input int y, input int dx, input int dy);
    fire_x  = CW'(x);
    fire_y  = CW'(y);
    fire_dx = VW'(dx);
    fire_dy = VW'(dy);
    fire_valid = 1'b1;
    step();
    fire_valid = 1'b0;
  endtask

  task automatic fire_exp(input int x, input int y, input int dx, input int dy, input logic [NS-1:0] act);
    exp_sfx_q.push_back(act);
    do_fire(x, y, dx, dy);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!fire_ready && n < 20) begin
      do_tick();
      n++;
    end
    if (!fire_ready) check("wait_ready_timeout", 32'(fire_ready), 1);
  endtask

  task automatic set_tgt(input int k, input int x, input int y);
    tgt_x[k*CW +: CW] = CW'(x);
    tgt_y[k*CW +: CW] = CW'(y);
  endtask

  // n slots hit n distinct targets on one tick.
  task automatic hit_round(input int n);
    tgt_active = '0;
    for (int i = 0; i < n; i++) begin
      wait_ready();
      fire_exp(100 * (i + 1), 100, 1, 0, NS'((1 << (i + 1)) - 1));
    end
    tgt_active = NT'((1 << n) - 1);
    exp_score = (exp_score + n > 99) ? 99 : exp_score + n;
    exp_hit_q.push_back({NT'((1 << n) - 1), 8'(exp_score)});
    do_tick();
    check("round_slots_free", 32'(slot_active), 0);
    tgt_active = '0;
  endtask

  // ---------------- stimulus ----------------
  int acc[$];
  int exp_acc[4] = '{0, 12, 24, 36};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_slot_active", 32'(slot_active), 0);
    check("rst_slot_x", 32'(slot_x), 0);
    check("rst_slot_y", 32'(slot_y), 0);
    check("rst_score", 32'(score), 0);
    check("rst_hit", 32'({hit_valid, hit_mask}), 0);
    check("rst_sfx", 32'(sfx_trig), 0);
    #3 rst_n = 1'b1;
    step();
    check("rst_ready", 32'(fire_ready), 1);

    // Basic fire and flight
    fire_exp(100, 200, 3, -2, 4'b0001);
    check("fire_slot_active", 32'(slot_active), 1);
    check("fire_ready_cool", 32'(fire_ready), 0);
    do_tick();
    check("cool_t1", 32'(fire_ready), 0);
    do_tick();
    check("cool_t2", 32'(fire_ready), 0);
    do_tick();
    check("cool_t3", 32'(fire_ready), 1);
    check("flight_x", 32'(sx(0)), 109);
    check("flight_y", 32'(sy(0)), 194);
    do_clear();
    check("clear_slots", 32'(slot_active), 0);

    // Cooldown spacing and full pool: fire every cycle, tick every 4 cycles
    fire_x = CW'(300); fire_y = CW'(300); fire_dx = VW'(1); fire_dy = VW'(1);
    fire_valid = 1'b1;
    for (int c = 0; c < 52; c++) begin
      tick = (c % 4 == 3);
      if (fire_ready) begin
        acc.push_back(c);
        exp_sfx_q.push_back(NS'((1 << acc.size()) - 1));
      end
      step();
    end
    tick = 1'b0;
    fire_valid = 1'b0;
    check("full_ready", 32'(fire_ready), 0);
    check("full_active", 32'(slot_active), 4'b1111);
    check("accept_count", 32'(acc.size()), 4);
    for (int i = 0; i < 4 && i < acc.size(); i++) check("accept_cycle", 32'(acc[i]), 32'(exp_acc[i]));
    do_clear();
    check("clear_ready", 32'(fire_ready), 1);

    // Zero velocity request is consumed without effect
    do_fire(10, 10, 0, 0);
    check("zero_slots", 32'(slot_active), 0);
    check("zero_ready", 32'(fire_ready), 1);
    fire_exp(300, 300, 1, 1, 4'b0001);
    check("zero_next_fire", 32'(slot_active), 1);
    do_clear();

    // Collision with target 2
    set_tgt(2, 45, 45);
    tgt_active = NT'(4);
    fire_exp(50, 50, 1, 1, 4'b0001);
    exp_hit_q.push_back({NT'(4), 8'(1)});
    do_tick();
    check("coll_slot_free", 32'(slot_active), 0);

    // Two slots on the same target: only the lower one claims it
    tgt_active = '0;
    wait_ready();
    fire_exp(50, 50, 1, 1, 4'b0001);
    wait_ready();
    fire_exp(50, 50, 1, 1, 4'b0011);
    tgt_active = NT'(4);
    exp_hit_q.push_back({NT'(4), 8'(2)});
    do_tick();
    check("shared_active", 32'(slot_active), 4'b0010);
    check("shared_x", 32'(sx(1)), 51);
    check("shared_y", 32'(sy(1)), 51);
    tgt_active = '0;
    do_clear();
    check("clear_score", 32'(score), 0);

    // Bounds: low edge, wrap past zero, high edge
    fire_exp(6, 240, -4, 0, 4'b0001);
    do_tick();
    check("low_x", 32'(sx(0)), 2);
    check("low_active", 32'(slot_active), 1);
    do_tick();
    check("low_out", 32'(slot_active), 0);
    check("low_frozen", 32'(sx(0)), 2);
    wait_ready();
    fire_exp(5, 100, -8, 0, 4'b0001);
    do_tick();
    check("wrap_x", 32'(sx(0)), 1021);
    do_tick();
    check("wrap_out", 32'(slot_active), 0);
    wait_ready();
    fire_exp(635, 240, 1, 0, 4'b0001);
    do_tick();
    check("high_edge_x", 32'(sx(0)), 636);
    check("high_edge_active", 32'(slot_active), 1);
    do_tick();
    check("high_out", 32'(slot_active), 0);
    do_clear();

    // Score saturation
    for (int k = 0; k < 4; k++) set_tgt(k, 100 * (k + 1) - 5, 95);
    exp_score = 0;
    for (int r = 0; r < 24; r++) hit_round(4);
    hit_round(2);
    check("score_98", 32'(score), 98);
    hit_round(3);
    check("score_sat", 32'(score), 99);

    // Clear beats tick and fire in the same cycle
    wait_ready();
    fire_exp(100, 100, 1, 0, 4'b0001);
    wait_ready();
    tgt_active = NT'(1);
    fire_x = CW'(200); fire_y = CW'(200); fire_dx = VW'(1); fire_dy = VW'(1);
    clear = 1'b1; tick = 1'b1; fire_valid = 1'b1;
    step();
    clear = 1'b0; tick = 1'b0; fire_valid = 1'b0;
    tgt_active = '0;
    check("clr_slots", 32'(slot_active), 0);
    check("clr_score", 32'(score), 0);
    check("clr_sfx", 32'(sfx_trig), 0);
    check("clr_hit", 32'(hit_valid), 0);
    check("clr_ready", 32'(fire_ready), 1);

    // Asynchronous reset mid-flight
    fire_exp(300, 300, 1, 1, 4'b0001);
    do_tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_active", 32'(slot_active), 0);
    check("arst_x", 32'(slot_x), 0);
    #2 rst_n = 1'b1;
    step();
    check("arst_ready", 32'(fire_ready), 1);

    repeat (3) step();
    check("sfx_queue_empty", 32'(exp_sfx_q.size()), 0);
    check("hit_queue_empty", 32'(exp_hit_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/projectile_pool.md
# projectile_pool

Parametrised multi-slot projectile engine for the arcade game top level. It replaces the single-bullet register set with a pool of `N_SLOTS` independent projectiles. Fire requests are accepted through a valid/ready handshake with a fire-rate cooldown. Active projectiles advance on a move-enable tick and are checked against up to `N_TARGETS` enemy boxes. The block outputs hit masks, a saturating score, a one-cycle sound-effect trigger and flattened slot state for the VGA renderer.

## Interface
- `N_SLOTS`, 4: number of projectile slots.
- `N_TARGETS`, 10: number of enemy boxes checked.
- `COORD_W`, 10: coordinate width, unsigned.
- `VEL_W`, 6: velocity width, signed two's complement.
- `SCR_W` / `SCR_H`, 640 / 480: screen size in pixels.
- `MARGIN`, 5: edge margin used by the bounds check.
- `BUL_W` / `BUL_H`, 5 / 10: projectile box size.
- `TGT_SZ`, 20: enemy box edge length.
- `COOLDOWN`, 3: ticks that must elapse between accepted fires.
- `SCORE_MAX`, 99: score saturation value.

Ports:
- `clk` in 1: system clock; the only clock in the block.
- `rst_n` in 1: asynchronous, active-low reset.
- `tick` in 1: one-cycle move/collision enable pulse, synchronous to `clk`.
- `clear` in 1: synchronous clear of slots, score and cooldown.
- `fire_valid` in 1: fire request.
- `fire_ready` out 1: the pool can accept a request this cycle.
- `fire_x`, `fire_y` in COORD_W: spawn position.
- `fire_dx`, `fire_dy` in VEL_W: signed velocity, applied per tick.
- `tgt_x`, `tgt_y` in N_TARGETS*COORD_W: flattened enemy top-left corners; target k occupies bits [k*COORD_W +: COORD_W].
- `tgt_active` in N_TARGETS: enemy valid bits.
- `slot_active` out N_SLOTS: occupied slots.
- `slot_x`, `slot_y` out N_SLOTS*COORD_W: flattened slot positions.
- `hit_valid` out 1: one-cycle pulse, at least one target was hit.
- `hit_mask` out N_TARGETS: targets hit; valid only while `hit_valid` is high, otherwise 0.
- `score` out 8: saturating hit count.
- `sfx_trig` out 1: one-cycle pulse for each accepted non-zero fire.

## Operation
- `fire_ready` is combinational: `(cooldown == 0) && (~&slot_active)`. It depends on registered state only and never on `fire_valid`.
- A fire is accepted when `fire_valid && fire_ready` at a clock edge.
  - If `fire_dx == 0 && fire_dy == 0`, the request is consumed and discarded: no slot is loaded, no `sfx_trig`, no cooldown.
  - Otherwise the lowest-index free slot loads `fire_x`, `fire_y`, `fire_dx` and `fire_dy` and becomes active.
  - On a loaded fire, `cooldown <= COOLDOWN` and `sfx_trig` pulses for one cycle.
- On each `tick`, every slot that is active at the edge is processed in this order:
  1. Collision check at the current position. Slot s hits target k when `tgt_active[k]` is set and all of the following hold: `sx+BUL_W > tx`, `sx < tx+TGT_SZ`, `sy+BUL_H > ty`, `sy < ty+TGT_SZ`. Sums are computed at COORD_W+1 bits so they cannot overflow.
  2. A hitting slot claims the lowest-index target it overlaps that is not already claimed by a lower-index slot in the same tick. If it claims a target, the slot deactivates. If every overlapped target is already claimed, the slot continues to the bounds step.
  3. Bounds check: the slot is in bounds iff `MARGIN <= x <= SCR_W-MARGIN` and `MARGIN <= y <= SCR_H-MARGIN`. An out-of-bounds slot deactivates and does not move.
  4. Move: `x <= x + sext(dx)` and `y <= y + sext(dy)`, modulo 2^COORD_W. An underflow wraps to a large value, which fails the next tick's bounds check.
- After all slots are processed, `score <= min(score + popcount(claimed targets), SCORE_MAX)`.
- `hit_valid` is the OR of the claimed targets. `hit_mask` is the set of claimed targets.
- `cooldown` decrements by 1 on each tick while it is non-zero.
- Simultaneous fire and tick in the same cycle:
  - The tick processes only the slots that were active before the edge. The newly loaded slot is not moved or checked until the next tick.
  - Slots freed by the tick cannot be loaded in that same cycle.
  - If the cooldown is being loaded by an accepted fire in this cycle, the load wins over the decrement.
- `clear`, sampled at a clock edge, takes priority over `tick` and fire. It zeroes all slots, `score` and `cooldown`; `hit_valid`, `hit_mask` and `sfx_trig` go to 0.

## Timing
- Reset (`rst_n` low, asynchronous): `slot_active`, `slot_x`, `slot_y`, `score`, `hit_valid`, `hit_mask`, `sfx_trig` and the internal cooldown and velocities are all 0. `fire_ready` is 1 as soon as reset deasserts.
- Fire: accepted at edge E. `slot_active` and `sfx_trig` are high in the cycle after E. `fire_ready` is low from E+1 until the COOLDOWN-th tick after E.
- Tick at edge T:
  - new positions, `slot_active`, `hit_valid`, `hit_mask` and `score` are all visible from T+1;
  - `hit_valid` is low again at T+2 unless another tick occurred at T+1.
- `rst_n` asserted mid-flight: all state clears immediately. There is no partial completion and no pending pulse survives.
- The block keeps no combinational path from the target inputs to any output. Targets are sampled only at tick edges.

## Test plan
- Reset release: `fire_ready=1` and all outputs 0. Fire at (100,200) with dx=3, dy=-2 -> slot 0 active and `sfx_trig` high for 1 cycle. After 3 ticks, `slot_x=109` and `slot_y=194`.
- Cooldown and full pool: fire on every cycle with ticks every 4 cycles -> accepts separated by exactly 3 ticks. After 4 accepts, `fire_ready=0` until a slot frees.
- Zero velocity: fire with dx=dy=0 -> `fire_ready` stays 1, no slot loads, no `sfx_trig`, and `cooldown` remains 0.
- Collision: slot at (50,50), target 2 at (45,45) active -> next tick gives `hit_valid=1`, `hit_mask=0b0000000100`, `score=1`, and the slot frees. Two slots on the same target -> one hit; the higher-index slot keeps moving.
- Bounds and wrap: slot at (6,240) with dx=-4 -> after the first tick x=2; after the second tick the slot deactivates with no hit. A slot with x wrapping past 0 deactivates on the following tick.
- Saturation and clear: preload `score` to 98, then a tick with 3 simultaneous hits -> `score=99`. Assert `clear` coincident with `tick` and fire -> all slots and `score` are 0 and there is no `sfx_trig`.
